fir_interp_poly: RTL and testbench
==================================

Name: fir_interp_poly

Overview:
- Parametrised polyphase interpolating FIR; successor to the fixed single-rate transposed FIR.
- Accepts one input sample per valid/ready handshake and emits INTERP output samples, phases 0..INTERP-1, each with its own valid/ready handshake.
- Coefficients are runtime-loadable through a write port.
- Full-precision accumulate, optional round-half-up right shift, output saturation.
- Sits between the sample source and the DAC-rate datapath of the interpolation chain.

Parameters:
DATA_WIDTH, 8, signed input sample width
COEFF_WIDTH, 8, signed coefficient width
OUT_WIDTH, 8, signed output width after shift/saturate
INTERP, 4, interpolation factor L (>=2)
TAPS_PER_PHASE, 4, taps per polyphase branch; total taps N = INTERP*TAPS_PER_PHASE
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_WIDTH  signed input sample
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_data  out  OUT_WIDTH  signed output sample
out_phase  out  clog2(INTERP)  polyphase index of out_data
coeff_we  in  1  coefficient write strobe
coeff_addr  in  clog2(N)  coefficient index k, 0..N-1
coeff_data  in  COEFF_WIDTH  signed coefficient h[k]
coeff_busy  out  1  high while not IDLE; writes are ignored when high
flush  in  1  synchronous clear of the delay line

Behaviour:
- Reset (asynchronous, rst=1) clears:
  - delay line x[0..TAPS_PER_PHASE-1] and all coefficients to 0;
  - state = IDLE, phase counter = 0;
  - out_valid=0, out_data=0, out_phase=0, in_ready=1, coeff_busy=0.
- Reset mid-burst abandons the burst; no partial phases resume after release.
- Delay line:
  - On input fire (in_valid & in_ready): x[0] <= in_data, x[j] <= x[j-1].
  - flush=1 in IDLE zeroes x[]. flush outside IDLE is ignored.
- Phase computation:
  - acc_p = sum over j=0..TAPS_PER_PHASE-1 of h[p + INTERP*j] * x[j], computed on the updated delay line.
  - ACC width = DATA_WIDTH + COEFF_WIDTH + clog2(TAPS_PER_PHASE); no internal overflow is possible.
- Output conversion:
  - If SHIFT>0: r = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. arithmetic round-half-up. If SHIFT=0: r = acc.
  - out_data = r saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- FSM states: IDLE, RUN.
- IDLE:
  - in_ready=1.
  - Input fire -> RUN. On the next edge out_valid=1, out_phase=0, out_data = phase-0 result (latency 1 cycle from input fire).
  - coeff_we writes h[coeff_addr] <= coeff_data. Addresses >= N are ignored.
- RUN:
  - out_valid=1. out_data and out_phase are held stable while out_ready=0.
  - Output fire with phase < INTERP-1: phase+1 result registered next cycle, out_valid stays 1 (one phase per cycle at full throughput).
  - Output fire at phase = INTERP-1 with in_valid=1 in the same cycle: the input is accepted (in_ready=1 only in this case within RUN), the delay line shifts, and the next cycle shows phase 0 of the new sample. This gives gapless back-to-back operation.
  - Output fire at phase = INTERP-1 without in_valid: go to IDLE, out_valid=0.
  - coeff_busy=1 and coeff_we is ignored.
- Sustained throughput: one input per INTERP cycles, one output per cycle.
- out_data is registered. in_ready is combinational from state, phase, and out_ready.

Test Plan:
- Impulse, defaults. Load h[k]=k for k=0..15, then feed 1,0,0,0,0 with out_ready=1 -> out_data sequence 0,1,2,3, 4,5,6,7, 8,9,10,11, 12,13,14,15, then 0,0,0,0. out_phase cycles 0..3; outputs are contiguous once inputs are presented every 4th cycle.
- Saturation. All h=127:
  - Four inputs of 127 -> every phase of the 4th sample outputs 127.
  - Four inputs of -128 -> -128.
  - Single input 1 -> 127 every phase, with no wrap.
- Rounding, SHIFT=1. h[0]=1, others 0:
  - input 3 -> phase0 = 2;
  - input -3 -> phase0 = -1;
  - input 2 -> phase0 = 1;
  - phases 1..3 = 0 in all cases.
- Backpressure. Hold out_ready=0 for 3 cycles while out_phase=1 -> out_data and out_phase stable, in_ready=0, no phase skipped or duplicated after release.
- Coefficient write while busy. Write h[0]=5 during RUN -> ignored, later impulse still shows the old h[0]. The same write in IDLE takes effect on the next sample.
- Reset mid-burst. Assert rst at phase 2 -> out_valid=0 immediately. After release, impulse output is all 0 because coefficients were cleared. flush in IDLE after inputs 7,7,7 -> the next impulse shows no residue.

Source files
------------

// File: rtl/fir_interp_poly.sv
// fir_interp_poly: polyphase interpolating FIR, one input sample in, INTERP phase outputs out,
// with runtime-loadable coefficients, round-half-up shift and output saturation.
module fir_interp_poly #(
  parameter int DATA_WIDTH     = 8,
  parameter int COEFF_WIDTH    = 8,
  parameter int OUT_WIDTH      = 8,
  parameter int INTERP         = 4,
  parameter int TAPS_PER_PHASE = 4,
  parameter int SHIFT          = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic signed [DATA_WIDTH-1:0]                 in_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic signed [OUT_WIDTH-1:0]                  out_data,
  output logic [$clog2(INTERP)-1:0]                    out_phase,
  input  logic                                         coeff_we,
  input  logic [$clog2(INTERP*TAPS_PER_PHASE)-1:0]     coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0]                coeff_data,
  output logic                                         coeff_busy,
  input  logic                                         flush
);
  localparam int N     = INTERP * TAPS_PER_PHASE;
  localparam int PW    = $clog2(INTERP);
  localparam int AW    = $clog2(N);
  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS_PER_PHASE);
  localparam logic signed [ACC_W:0] RND  = (ACC_W + 1)'(2 ** SHIFT / 2);
  localparam logic signed [ACC_W:0] OMAX = (ACC_W + 1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [ACC_W:0] OMIN = ~OMAX;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                        state_q, state_d;
  logic [PW-1:0]                 phase_q, phase_d;
  logic signed [DATA_WIDTH-1:0]  x_q [TAPS_PER_PHASE];
  logic signed [DATA_WIDTH-1:0]  x_d [TAPS_PER_PHASE];
  logic signed [COEFF_WIDTH-1:0] h_q [N];
  logic signed [COEFF_WIDTH-1:0] h_d [N];
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W:0]         rnd;
  logic                          last, in_fire, out_fire, load;

  assign last     = phase_q == PW'(INTERP - 1);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign load     = in_fire || (out_fire && !last);

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb
    state_d = state_q == IDLE ? (in_fire ? RUN : IDLE) : (out_fire && last && !in_fire ? IDLE : RUN);

  // Within RUN a new sample is taken only as the last phase leaves, keeping bursts gapless.
  always_comb begin
    in_ready   = state_q == IDLE || (out_ready && last);
    out_valid  = state_q == RUN;
    coeff_busy = state_q != IDLE;
    out_data   = out_data_q;
    out_phase  = phase_q;
  end

  always_comb begin
    phase_d = in_fire ? '0 : out_fire ? (last ? '0 : phase_q + PW'(1)) : phase_q;
    x_d = x_q;
    if (in_fire) begin
      x_d[0] = in_data;
      for (int j = 1; j < TAPS_PER_PHASE; j++) x_d[j] = x_q[j-1];
    end else if (flush && state_q == IDLE) begin
      for (int j = 0; j < TAPS_PER_PHASE; j++) x_d[j] = '0;
    end
    h_d = h_q;
    if (coeff_we && state_q == IDLE && int'(coeff_addr) < N) h_d[coeff_addr] = coeff_data;
    // The phase being registered is evaluated on the post-shift delay line.
    acc = '0;
    for (int j = 0; j < TAPS_PER_PHASE; j++)
      acc += ACC_W'(h_q[AW'(INTERP * j) + AW'(phase_d)]) * ACC_W'(x_d[j]);
    rnd = ((ACC_W + 1)'(acc) + RND) >>> SHIFT;
    out_data_d = !load ? out_data_q :
                 rnd > OMAX ? OMAX[OUT_WIDTH-1:0] :
                 rnd < OMIN ? OMIN[OUT_WIDTH-1:0] : rnd[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase_q    <= '0;
      x_q        <= '{default: '0};
      h_q        <= '{default: '0};
      out_data_q <= '0;
    end else begin
      phase_q    <= phase_d;
      x_q        <= x_d;
      h_q        <= h_d;
      out_data_q <= out_data_d;
    end
endmodule

// File: tb/tb_fir_interp_poly.sv
// tb_fir_interp_poly: table-driven scoreboard bench; a SHIFT=0 and a SHIFT=1 instance share all stimulus.
module tb_fir_interp_poly;
  typedef struct {
    logic signed [7:0] din;
    logic [0:3][7:0]   e0;
    logic [0:3][7:0]   e1;
  } vec_t;
  typedef struct {
    logic signed [7:0] d0;
    logic signed [7:0] d1;
    logic [1:0]        ph;
  } exp_t;

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, coeff_we = 0, flush = 0;
  logic signed [7:0] in_data = '0, coeff_data = '0;
  logic [3:0] coeff_addr = '0;
  logic in_ready, out_valid, coeff_busy, in_ready1, out_valid1, coeff_busy1;
  logic signed [7:0] out_data, out_data1;
  logic [1:0] out_phase, out_phase1;
  int tests = 0, fails = 0;
  exp_t sb[$];
  vec_t tab[$];
  exp_t got;

  fir_interp_poly dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_phase(out_phase),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .coeff_busy(coeff_busy), .flush(flush));

  fir_interp_poly #(.SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_phase(out_phase1),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .coeff_busy(coeff_busy1), .flush(flush));

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endfunction

  function automatic vec_t mk(int d, int a0, int a1, int a2, int a3, int b0, int b1, int b2, int b3);
    vec_t r;
    r.din = 8'(d);
    r.e0  = {8'(a0), 8'(a1), 8'(a2), 8'(a3)};
    r.e1  = {8'(b0), 8'(b1), 8'(b2), 8'(b3)};
    return r;
  endfunction

  function automatic vec_t mkc(int d, int a, int b);
    return mk(d, a, a, a, a, b, b, b, b);
  endfunction

  always @(negedge clk)
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_out: phase %0d data %0d with nothing expected", out_phase, out_data);
      end else begin
        got = sb.pop_front();
        chk("data_shift0", int'(out_data), int'(got.d0));
        chk("data_shift1", int'(out_data1), int'(got.d1));
        chk("phase", int'(out_phase), int'(got.ph));
        chk("phase_shift1", int'(out_phase1), int'(got.ph));
        chk("valid_shift1", int'(out_valid1), 1);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    coeff_addr = 4'(a);
    coeff_data = 8'(d);
    coeff_we   = 1;
    tick();
    coeff_we   = 0;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 16; k++) wr(k, k);
  endtask

  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    int n;
    in_data  = v.din;
    in_valid = 1;
    for (int p = 0; p < 4; p++) begin
      e.d0 = $signed(v.e0[p]);
      e.d1 = $signed(v.e1[p]);
      e.ph = 2'(p);
      sb.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", int'(in_ready), 1);
    tick();
    in_valid = 0;
  endtask

  task automatic run_tab();
    foreach (tab[i]) send(tab[i]);
    tab.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_queue", sb.size(), 0);
    chk("drain_idle", int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_phase", int'(out_phase), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_coeff_busy", int'(coeff_busy), 0);
    chk("rst_out_valid1", int'(out_valid1), 0);
    chk("rst_in_ready1", int'(in_ready1), 1);
    chk("rst_coeff_busy1", int'(coeff_busy1), 0);
    rst = 0;
    tick();

    load_ramp();
    tab.push_back(mk(1, 0, 1, 2, 3, 0, 1, 1, 2));
    tab.push_back(mk(0, 4, 5, 6, 7, 2, 3, 3, 4));
    tab.push_back(mk(0, 8, 9, 10, 11, 4, 5, 5, 6));
    tab.push_back(mk(0, 12, 13, 14, 15, 6, 7, 7, 8));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_tab();
    drain();

    for (int k = 0; k < 16; k++) wr(k, 127);
    repeat (4) tab.push_back(mkc(127, 127, 127));
    tab.push_back(mkc(-128, 127, 127));
    tab.push_back(mkc(-128, -128, -127));
    tab.push_back(mkc(-128, -128, -128));
    tab.push_back(mkc(-128, -128, -128));
    run_tab();
    drain();
    do_flush();
    tab.push_back(mkc(1, 127, 64));
    run_tab();
    drain();

    for (int k = 0; k < 16; k++) wr(k, k == 0 ? 1 : 0);
    tab.push_back(mk(3, 3, 0, 0, 0, 2, 0, 0, 0));
    tab.push_back(mk(-3, -3, 0, 0, 0, -1, 0, 0, 0));
    tab.push_back(mk(2, 2, 0, 0, 0, 1, 0, 0, 0));
    run_tab();
    drain();

    do_flush();
    load_ramp();
    send(mk(1, 0, 1, 2, 3, 0, 1, 1, 2));
    tick();
    out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_phase", int'(out_phase), 1);
      chk("bp_data", int'(out_data), 1);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    tick();
    out_ready = 1;
    drain();

    do_flush();
    send(mk(1, 0, 1, 2, 3, 0, 1, 1, 2));
    chk("busy_in_run", int'(coeff_busy), 1);
    wr(0, 5);
    drain();
    do_flush();
    send(mk(1, 0, 1, 2, 3, 0, 1, 1, 2));
    drain();
    chk("busy_in_idle", int'(coeff_busy), 0);
    wr(0, 5);
    do_flush();
    send(mk(1, 5, 1, 2, 3, 3, 1, 1, 2));
    drain();

    do_flush();
    send(mk(1, 5, 1, 2, 3, 3, 1, 1, 2));
    tick();
    tick();
    chk("rst_pre_phase", int'(out_phase), 2);
    rst = 1;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_phase", int'(out_phase), 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_busy", int'(coeff_busy), 0);
    sb.delete();
    tick();
    rst = 0;
    tick();
    send(mkc(1, 0, 0));
    drain();

    load_ramp();
    do_flush();
    tab.push_back(mk(7, 0, 7, 14, 21, 0, 4, 7, 11));
    tab.push_back(mk(7, 28, 42, 56, 70, 14, 21, 28, 35));
    tab.push_back(mk(7, 84, 105, 126, 127, 42, 53, 63, 74));
    run_tab();
    drain();
    do_flush();
    send(mk(1, 0, 1, 2, 3, 0, 1, 1, 2));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
